// File: rtl/loader_pkg.sv
// -----------------------------------------------------------------------------
// loader_pkg
// Shared types for the loader write sequencer slice.
//   loader_seq_state_t : sequencer FSM states (IDLE, LOAD, UNPACK)
//   bridge_word_t      : one buffered bridge write, {addr, data}
//   BYTES_PER_WORD     : number of byte writes produced per bridge word
//   word_byte()        : little-endian byte lane select helper
// -----------------------------------------------------------------------------
package loader_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    UNPACK = 2'd2
  } loader_seq_state_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } bridge_word_t;

  localparam int BYTES_PER_WORD = 4;

  // Byte k of a word lives in bits [8k+7:8k] (little-endian lane order).
  function automatic logic [7:0] word_byte(input logic [31:0] word, input logic [1:0] k);
    return word[{k, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/loader_write_sequencer_sync_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo
// Single-clock FIFO with registered pointers and an occupancy counter.
// A push is accepted when the FIFO is not full, or when it is full and a pop
// happens in the same cycle (the freed slot is reused immediately). A pop on
// an empty FIFO is ignored. rd_data always shows the current head entry.
//   clk, reset      : clock and asynchronous active-high reset
//   push, wr_data   : write request and data
//   pop             : remove head entry
//   rd_data         : head entry (valid when empty=0)
//   full, empty     : occupancy flags
// -----------------------------------------------------------------------------
module sync_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic push_ok;
  logic pop_ok;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign rd_data = mem_q[rd_ptr_q];

  // Pop is evaluated first so a full FIFO can accept a push in the pop cycle.
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);

  // DEPTH is a power of two, so pointers wrap by natural overflow.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = wr_data;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: emptiness is tracked by the pointers/counter.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/loader_write_sequencer.sv
// -----------------------------------------------------------------------------
// loader_write_sequencer
// Buffers 32-bit bridge writes in a FIFO, unpacks each word into four
// little-endian byte writes (addr+k, data[8k+7:8k]) and shares the single
// byte-wide memory port with a core-side requester.
//   clk, reset                      : clock, asynchronous active-high reset
//   bridge_addr/_wr_data/_wr        : bridge word write (one-cycle strobe)
//   core_req/_addr/_data, core_grant: core byte request; grant is combinational
//   mem_address/_data/_wr           : registered byte write port
//   busy                            : FIFO non-empty or a word in progress
//   overflow, overflow_clear        : sticky dropped-write flag and its clear
// -----------------------------------------------------------------------------
module loader_write_sequencer
  import loader_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] bridge_addr,
  input  logic [31:0] bridge_wr_data,
  input  logic        bridge_wr,
  input  logic        core_req,
  input  logic [31:0] core_addr,
  input  logic [7:0]  core_data,
  output logic        core_grant,
  output logic [31:0] mem_address,
  output logic [7:0]  mem_data,
  output logic        mem_wr,
  output logic        busy,
  output logic        overflow,
  input  logic        overflow_clear
);

  localparam int WORD_W = $bits(bridge_word_t);

  loader_seq_state_t state_q, state_d;
  bridge_word_t      word_q, word_d;
  logic [1:0]        idx_q, idx_d;
  logic              core_prio_q, core_prio_d;
  logic              overflow_q, overflow_d;
  logic [31:0]       mem_address_q, mem_address_d;
  logic [7:0]        mem_data_q, mem_data_d;
  logic              mem_wr_q, mem_wr_d;

  logic              fifo_pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [WORD_W-1:0] fifo_rd_data;
  bridge_word_t      fifo_head;

  logic              loader_req;
  logic              loader_win;
  logic              core_win;

  bridge_word_t      bridge_word;

  assign bridge_word = '{addr: bridge_addr, data: bridge_wr_data};
  assign fifo_head   = bridge_word_t'(fifo_rd_data);

  sync_fifo #(
    .WIDTH (WORD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (bridge_wr),
    .wr_data (WORD_W'(bridge_word)),
    .pop     (fifo_pop),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // Arbiter: core_prio_q records that the loader won the last contested
  // cycle, so the core has priority on the next one. Reset gives the loader
  // first turn.
  always_comb begin
    loader_req  = (state_q == UNPACK);
    loader_win  = loader_req & (~core_req | ~core_prio_q);
    core_win    = core_req & ~loader_win;
    core_prio_d = core_prio_q;
    if (loader_req && core_req) begin
      core_prio_d = loader_win;
    end
  end

  // Grant is masked during reset so no byte is accepted while the port is
  // being cleared.
  assign core_grant = core_win & ~reset;

  // Sequencer FSM. IDLE also reacts to a push in the current cycle so the
  // word reaches LOAD one cycle after the bridge strobe. After the last byte
  // of a word, a waiting FIFO entry is reloaded directly with no bubble.
  always_comb begin
    state_d  = state_q;
    word_d   = word_q;
    idx_d    = idx_q;
    fifo_pop = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty || bridge_wr) begin
          state_d = LOAD;
        end
      end
      LOAD: begin
        fifo_pop = 1'b1;
        word_d   = fifo_head;
        idx_d    = 2'd0;
        state_d  = UNPACK;
      end
      UNPACK: begin
        if (loader_win) begin
          idx_d = idx_q + 2'd1;
          if (idx_q == 2'(BYTES_PER_WORD - 1)) begin
            if (!fifo_empty) begin
              fifo_pop = 1'b1;
              word_d   = fifo_head;
              idx_d    = 2'd0;
            end else begin
              state_d = IDLE;
            end
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output register: the winner of this cycle drives the port next cycle.
  // Address/data hold their last value when nobody wins.
  always_comb begin
    mem_wr_d      = loader_win | core_win;
    mem_address_d = mem_address_q;
    mem_data_d    = mem_data_q;
    if (loader_win) begin
      mem_address_d = word_q.addr + 32'(idx_q);
      mem_data_d    = word_byte(word_q.data, idx_q);
    end else if (core_win) begin
      mem_address_d = core_addr;
      mem_data_d    = core_data;
    end
  end

  // Sticky overflow: a new drop in the same cycle as a clear keeps the flag.
  always_comb begin
    overflow_d = overflow_q;
    if (overflow_clear) begin
      overflow_d = 1'b0;
    end
    if (bridge_wr && fifo_full && !fifo_pop) begin
      overflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      word_q        <= '0;
      idx_q         <= '0;
      core_prio_q   <= 1'b0;
      overflow_q    <= 1'b0;
      mem_address_q <= '0;
      mem_data_q    <= '0;
      mem_wr_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      word_q        <= word_d;
      idx_q         <= idx_d;
      core_prio_q   <= core_prio_d;
      overflow_q    <= overflow_d;
      mem_address_q <= mem_address_d;
      mem_data_q    <= mem_data_d;
      mem_wr_q      <= mem_wr_d;
    end
  end

  assign mem_address = mem_address_q;
  assign mem_data    = mem_data_q;
  assign mem_wr      = mem_wr_q;
  assign overflow    = overflow_q;
  assign busy        = (state_q != IDLE) | ~fifo_empty;

endmodule
